fourway_phase_sequencer: RTL and testbench
==========================================

# fourway_phase_sequencer

Intersection-level sequencer that sits directly upstream of the four per-approach traffic-light controllers. It owns each light's `EN` and `SETCOUNTER` inputs. Before enabling the lights, it preloads them with staggered counts so that exactly one approach at a time is in green/yellow over a 120-tick cycle. It monitors the lights' green/yellow outputs and forces all approaches to red when it detects a conflict.

## Interface
Parameters:
- `PHASE_LEN`, 30: ticks of green plus yellow per approach; also the preload stagger step.
- `CYCLE_LEN`, 120: full intersection cycle in ticks; equals 4*`PHASE_LEN`.
- `LOAD_CYCLES`, 2: cycles that `EN` is held low with the staggered preloads applied (≥1).
- `RED_LOAD`, 120: `SETCOUNTER` value that forces a light to red.

Ports:
- `CLK`, in, 1: clock; one tick per cycle, the same clock that drives the lights.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `START`, in, 1: request to begin sequencing; honoured in IDLE only.
- `STOP`, in, 1: return to IDLE; honoured in LOAD and RUN.
- `CLR_FAULT`, in, 1: leave FAULT.
- `FIRST_SEL`, in, 2: approach that receives the first green; sampled when START is accepted.
- `GREEN_IN`, in, 4: green outputs of lights 0..3.
- `YELLOW_IN`, in, 4: yellow outputs of lights 0..3.
- `EN_OUT`, out, 4: per-light `EN`.
- `SETCOUNTER_OUT`, out, 64: light k at bits [16k+15:16k].
- `FAULT`, out, 1: conflict latched.
- `STATE_OUT`, out, 2: current state encoding.
- `CYCLE_POS`, out, 7: position in the cycle, 0..`CYCLE_LEN`-1.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `EN_OUT`=0000, every `SETCOUNTER` lane=`RED_LOAD`, `FAULT`=0, `CYCLE_POS`=0, latched first-approach select=0.
- Preload for lane k is `PHASE_LEN`*(((k − first) mod 4)+1). With the default parameters the values are 30, 60, 90 and 120. The first approach therefore loads green with 25 remaining, and the others load red with 30, 60 and 90 remaining.
- States and transitions:
  - IDLE: EN=0000, all lanes=`RED_LOAD`. START → LOAD; latch `FIRST_SEL`; load counter = `LOAD_CYCLES`−1.
  - LOAD: EN=0000, lanes=preloads. STOP → IDLE. Otherwise, when counter=0 → RUN with `CYCLE_POS`=0; else decrement the counter.
  - RUN: EN=1111, lanes hold the preloads. `CYCLE_POS` increments each cycle and wraps from `CYCLE_LEN`−1 to 0. A conflict → FAULT. Otherwise STOP → IDLE. START is ignored.
  - FAULT: EN=0000, all lanes=`RED_LOAD`, `FAULT`=1. CLR_FAULT → IDLE, which clears `FAULT`. START and STOP are ignored.
- Conflict definition: popcount(`GREEN_IN` | `YELLOW_IN`) > 1. It is evaluated only in RUN. Zero active approaches is not a conflict, because one-tick gaps at handover are legal.
- Priorities:
  - In RUN, conflict takes priority over STOP.
  - In IDLE, START takes priority over STOP.
  - In FAULT, CLR_FAULT is the only exit, even if the conflict inputs are still asserted.
- `CYCLE_POS` holds 0 outside RUN.

## Timing
- START sampled high at edge N in IDLE → after edge N the block is in LOAD, with preloads on the lanes and EN still 0.
- After `LOAD_CYCLES` edges in LOAD → RUN, with `EN_OUT`=1111 visible. With the default of 2, EN rises 3 edges after START.
- Conflict sampled at edge N in RUN → after edge N the block is in FAULT, with EN=0000 and all lanes at `RED_LOAD`. Latency is one edge.
- STOP at edge N in RUN or LOAD → IDLE after edge N.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. On release, operation resumes from IDLE on the next edge.

## Structure
- Shared package `traffic_pkg`:
  - state encoding: IDLE=0, LOAD=1, RUN=2, FAULT=3.
  - `PHASE_LEN`, `CYCLE_LEN` and `RED_LOAD` defaults, shared with the light controller so the cycle constants stay in one place.
- Sub-module `conflict_check`: combinational. Takes green[4] and yellow[4], produces a one-bit conflict flag from the popcount > 1 rule. It is reused later for pedestrian-phase checks.

## Test plan
- Reset: pulse `RST_N` low → `EN_OUT`=0000, all four lanes=120, `FAULT`=0, `CYCLE_POS`=0, `STATE_OUT`=0.
- Start, default select: START with `FIRST_SEL`=0 → next edge lanes 0..3 = 30/60/90/120 and EN=0000; 2 edges later EN=1111 and `STATE_OUT`=2.
- Rotated select: START with `FIRST_SEL`=2 → lane2=30, lane3=60, lane0=90, lane1=120.
- Conflict and recovery: in RUN, drive `GREEN_IN`=0001 and `YELLOW_IN`=0100 → next edge `FAULT`=1, EN=0000, all lanes=120. Hold CLR_FAULT low for 10 cycles → FAULT persists. Pulse CLR_FAULT → IDLE with `FAULT`=0.
- Wrap and priority: run 120 cycles → `CYCLE_POS` goes 119→0. Assert STOP together with `GREEN_IN`=0011 → FAULT, not IDLE. STOP alone in LOAD → IDLE.
- Asynchronous reset mid-RUN: drop `RST_N` between edges → outputs reach reset values before the next `CLK` edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared intersection constants, state encoding and preload helper used by the
// sequencer and the per-approach light controllers.
package traffic_pkg;

  localparam int unsigned PHASE_LEN_DEF = 30;
  localparam int unsigned CYCLE_LEN_DEF = 120;
  localparam int unsigned RED_LOAD_DEF  = 120;
  localparam int unsigned NUM_LANES     = 4;
  localparam int unsigned LANE_W        = 16;
  localparam int unsigned POS_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Staggered preload: the first approach gets one phase, each later one a phase more.
  function automatic logic [LANE_W-1:0] preload_value(input logic [1:0]   lane,
                                                      input logic [1:0]   first,
                                                      input int unsigned  phase_len);
    logic [1:0] offset;
    offset = lane - first;
    return LANE_W'(phase_len * (32'(offset) + 32'd1));
  endfunction

endpackage

// File: rtl/fourway_phase_sequencer_if.sv
// Control/monitor bundle between the sequencer and the four light controllers.
interface fourway_phase_sequencer_if;
  import traffic_pkg::*;

  logic                          START;
  logic                          STOP;
  logic                          CLR_FAULT;
  logic [1:0]                    FIRST_SEL;
  logic [NUM_LANES-1:0]          GREEN_IN;
  logic [NUM_LANES-1:0]          YELLOW_IN;
  logic [NUM_LANES-1:0]          EN_OUT;
  logic [NUM_LANES*LANE_W-1:0]   SETCOUNTER_OUT;
  logic                          FAULT;
  logic [1:0]                    STATE_OUT;
  logic [POS_W-1:0]              CYCLE_POS;

  modport master (
    output START, STOP, CLR_FAULT, FIRST_SEL, GREEN_IN, YELLOW_IN,
    input  EN_OUT, SETCOUNTER_OUT, FAULT, STATE_OUT, CYCLE_POS
  );

  modport slave (
    input  START, STOP, CLR_FAULT, FIRST_SEL, GREEN_IN, YELLOW_IN,
    output EN_OUT, SETCOUNTER_OUT, FAULT, STATE_OUT, CYCLE_POS
  );

endinterface

// File: rtl/conflict_check.sv
// Flags more than one approach showing green or yellow at the same time.
module conflict_check
  import traffic_pkg::*;
(
  input  logic [NUM_LANES-1:0] green,
  input  logic [NUM_LANES-1:0] yellow,
  output logic                 conflict_c
);

  logic [NUM_LANES-1:0] active;
  logic [2:0]           count;

  always_comb begin
    active = green | yellow;
    count  = 3'd0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      count = count + 3'(active[i]);
    end
  end

  // An empty intersection is a legal handover gap, so only two or more counts.
  assign conflict_c = (count > 3'd1);

endmodule

// File: rtl/fourway_phase_sequencer.sv
// Intersection sequencer: preloads staggered counts into four lights, runs them,
// and forces all-red on a green/yellow conflict until cleared.
module fourway_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned PHASE_LEN   = PHASE_LEN_DEF,
  parameter int unsigned CYCLE_LEN   = CYCLE_LEN_DEF,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned RED_LOAD    = RED_LOAD_DEF
) (
  input logic                      CLK,
  input logic                      RST_N,
  fourway_phase_sequencer_if.slave bus
);

  localparam int unsigned LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int unsigned BUS_W  = NUM_LANES * LANE_W;
  localparam logic [BUS_W-1:0] RED_LANES = {NUM_LANES{LANE_W'(RED_LOAD)}};

  state_t               state, state_next;
  logic [1:0]           first_q, first_next;
  logic [LOAD_W-1:0]    load_cnt, load_cnt_next;
  logic [POS_W-1:0]     pos, pos_next;
  logic [NUM_LANES-1:0] en, en_next;
  logic [BUS_W-1:0]     lanes, lanes_next, preload_lanes;
  logic                 fault, fault_next;
  logic                 conflict_c;

  conflict_check u_conflict (
    .green      (bus.GREEN_IN),
    .yellow     (bus.YELLOW_IN),
    .conflict_c (conflict_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      first_q  <= 2'd0;
      load_cnt <= '0;
      pos      <= '0;
      en       <= '0;
      lanes    <= RED_LANES;
      fault    <= 1'b0;
    end else begin
      state    <= state_next;
      first_q  <= first_next;
      load_cnt <= load_cnt_next;
      pos      <= pos_next;
      en       <= en_next;
      lanes    <= lanes_next;
      fault    <= fault_next;
    end
  end

  // Next state, then the registered outputs that the next state implies.
  always_comb begin
    state_next    = state;
    first_next    = first_q;
    load_cnt_next = load_cnt;
    pos_next      = '0;
    en_next       = '0;
    lanes_next    = RED_LANES;
    fault_next    = 1'b0;
    preload_lanes = '0;

    unique case (state)
      ST_IDLE: begin
        if (bus.START) begin
          state_next    = ST_LOAD;
          first_next    = bus.FIRST_SEL;
          load_cnt_next = LOAD_W'(LOAD_CYCLES - 1);
        end
      end
      ST_LOAD: begin
        if (bus.STOP)                state_next = ST_IDLE;
        else if (load_cnt == '0)     state_next = ST_RUN;
        else                         load_cnt_next = load_cnt - LOAD_W'(1);
      end
      ST_RUN: begin
        if (conflict_c)    state_next = ST_FAULT;
        else if (bus.STOP) state_next = ST_IDLE;
        else pos_next = (pos == POS_W'(CYCLE_LEN - 1)) ? '0 : pos + POS_W'(1);
      end
      ST_FAULT: begin
        if (bus.CLR_FAULT) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      preload_lanes[k*LANE_W +: LANE_W] = preload_value(2'(k), first_next, PHASE_LEN);
    end

    unique case (state_next)
      ST_LOAD:  lanes_next = preload_lanes;
      ST_RUN: begin
        en_next    = '1;
        lanes_next = preload_lanes;
      end
      ST_FAULT: fault_next = 1'b1;
      default: ;
    endcase
  end

  assign bus.EN_OUT         = en;
  assign bus.SETCOUNTER_OUT = lanes;
  assign bus.FAULT          = fault;
  assign bus.STATE_OUT      = state;
  assign bus.CYCLE_POS      = pos;

endmodule

// File: tb/tb_fourway_phase_sequencer.sv
// Directed and randomized checks of the four-way phase sequencer against a
// behavioural intersection model.
module tb_fourway_phase_sequencer;

  localparam int PHASE = 30;
  localparam int CYCLE = 120;
  localparam int LOADC = 2;
  localparam int RED   = 120;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: 0 idle, 1 load, 2 run, 3 fault
  int m_state = 0;
  int m_first = 0;
  int m_load_left = 0;
  int m_pos = 0;

  fourway_phase_sequencer_if bus();

  fourway_phase_sequencer #(
    .PHASE_LEN(PHASE), .CYCLE_LEN(CYCLE), .LOAD_CYCLES(LOADC), .RED_LOAD(RED)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic int exp_preload(input int k, input int first);
    return PHASE * (((((k - first) % 4) + 4) % 4) + 1);
  endfunction

  function automatic int lane(input int k);
    logic [63:0] v;
    v = bus.SETCOUNTER_OUT;
    return int'(v[16*k +: 16]);
  endfunction

  task automatic model_step();
    logic [3:0] act;
    act = bus.GREEN_IN | bus.YELLOW_IN;
    case (m_state)
      0: if (bus.START) begin
           m_state = 1; m_first = int'(bus.FIRST_SEL); m_load_left = LOADC;
         end
      1: if (bus.STOP) m_state = 0;
         else begin
           m_load_left--;
           if (m_load_left == 0) begin m_state = 2; m_pos = -1; end
         end
      2: if ($countones(act) > 1) m_state = 3;
         else if (bus.STOP) m_state = 0;
      3: if (bus.CLR_FAULT) m_state = 0;
      default: m_state = 0;
    endcase
    m_pos = (m_state == 2) ? (m_pos + 1) % CYCLE : 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.START = 0; bus.STOP = 0; bus.CLR_FAULT = 0; bus.FIRST_SEL = 0;
    bus.GREEN_IN = 0; bus.YELLOW_IN = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST_N = 0;
    @(negedge CLK); @(negedge CLK);
    RST_N = 1;
    m_state = 0; m_first = 0; m_load_left = 0; m_pos = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST_N = 0;
    @(negedge CLK); @(negedge CLK);
    n_tests++;
    if (bus.EN_OUT !== 4'b0000 || bus.FAULT !== 1'b0 || bus.CYCLE_POS !== 7'd0 ||
        bus.STATE_OUT !== 2'd0 || bus.SETCOUNTER_OUT !== {4{16'd120}}) begin
      n_fail++;
      $display("FAIL reset en=%b fault=%b pos=%0d state=%0d lanes=%h exp en=0000 fault=0 pos=0 state=0 lanes=0078x4",
               bus.EN_OUT, bus.FAULT, bus.CYCLE_POS, bus.STATE_OUT, bus.SETCOUNTER_OUT);
    end
    RST_N = 1;
    m_state = 0; m_first = 0; m_load_left = 0; m_pos = 0;
    #1;
  endtask

  task automatic test_start_default();
    bus.START = 1; bus.FIRST_SEL = 2'd0;
    tick();
    bus.START = 0;
    n_tests++;
    if (lane(0) != 30 || lane(1) != 60 || lane(2) != 90 || lane(3) != 120 ||
        bus.EN_OUT !== 4'b0000 || bus.STATE_OUT !== 2'd1) begin
      n_fail++;
      $display("FAIL start_load lanes=%0d/%0d/%0d/%0d en=%b state=%0d exp 30/60/90/120 en=0000 state=1",
               lane(0), lane(1), lane(2), lane(3), bus.EN_OUT, bus.STATE_OUT);
    end
    tick();
    n_tests++;
    if (bus.EN_OUT !== 4'b0000) begin
      n_fail++; $display("FAIL start_en_early got=%b exp=0000", bus.EN_OUT);
    end
    tick();
    n_tests++;
    if (bus.EN_OUT !== 4'b1111 || bus.STATE_OUT !== 2'd2 || bus.CYCLE_POS !== 7'd0) begin
      n_fail++;
      $display("FAIL start_run en=%b state=%0d pos=%0d exp en=1111 state=2 pos=0",
               bus.EN_OUT, bus.STATE_OUT, bus.CYCLE_POS);
    end
    bus.STOP = 1; tick(); bus.STOP = 0;
    n_tests++;
    if (bus.STATE_OUT !== 2'd0 || bus.EN_OUT !== 4'b0000) begin
      n_fail++; $display("FAIL stop_run state=%0d en=%b exp state=0 en=0000", bus.STATE_OUT, bus.EN_OUT);
    end
  endtask

  task automatic test_rotated();
    bus.START = 1; bus.FIRST_SEL = 2'd2;
    tick();
    bus.START = 0; bus.FIRST_SEL = 2'd1;
    n_tests++;
    if (lane(2) != 30 || lane(3) != 60 || lane(0) != 90 || lane(1) != 120) begin
      n_fail++;
      $display("FAIL rotated lanes0..3=%0d/%0d/%0d/%0d exp 90/120/30/60", lane(0), lane(1), lane(2), lane(3));
    end
    tick(); tick();
    n_tests++;
    if (lane(2) != 30 || lane(1) != 120 || bus.EN_OUT !== 4'b1111) begin
      n_fail++;
      $display("FAIL rotated_run lane2=%0d lane1=%0d en=%b exp 30 120 1111", lane(2), lane(1), bus.EN_OUT);
    end
  endtask

  task automatic test_conflict();
    bus.GREEN_IN = 4'b0001; bus.YELLOW_IN = 4'b0100;
    tick();
    n_tests++;
    if (bus.FAULT !== 1'b1 || bus.EN_OUT !== 4'b0000 || bus.STATE_OUT !== 2'd3 ||
        bus.SETCOUNTER_OUT !== {4{16'd120}}) begin
      n_fail++;
      $display("FAIL conflict fault=%b en=%b state=%0d lanes=%h exp 1 0000 3 0078x4",
               bus.FAULT, bus.EN_OUT, bus.STATE_OUT, bus.SETCOUNTER_OUT);
    end
    bus.START = 1; bus.STOP = 1;
    for (int i = 0; i < 10; i++) tick();
    bus.START = 0; bus.STOP = 0;
    n_tests++;
    if (bus.FAULT !== 1'b1 || bus.STATE_OUT !== 2'd3) begin
      n_fail++; $display("FAIL fault_hold fault=%b state=%0d exp 1 3", bus.FAULT, bus.STATE_OUT);
    end
    bus.CLR_FAULT = 1; tick(); bus.CLR_FAULT = 0;
    bus.GREEN_IN = 0; bus.YELLOW_IN = 0;
    n_tests++;
    if (bus.FAULT !== 1'b0 || bus.STATE_OUT !== 2'd0) begin
      n_fail++; $display("FAIL clr_fault fault=%b state=%0d exp 0 0", bus.FAULT, bus.STATE_OUT);
    end
  endtask

  task automatic test_wrap_priority();
    bus.START = 1; bus.FIRST_SEL = 2'd3; tick(); bus.START = 0;
    tick(); tick();
    for (int i = 0; i < 119; i++) tick();
    n_tests++;
    if (bus.CYCLE_POS !== 7'd119) begin
      n_fail++; $display("FAIL wrap_pre got=%0d exp=119", bus.CYCLE_POS);
    end
    tick();
    n_tests++;
    if (bus.CYCLE_POS !== 7'd0 || bus.STATE_OUT !== 2'd2) begin
      n_fail++; $display("FAIL wrap got=%0d state=%0d exp 0 2", bus.CYCLE_POS, bus.STATE_OUT);
    end
    bus.STOP = 1; bus.GREEN_IN = 4'b0011; tick();
    bus.STOP = 0; bus.GREEN_IN = 0;
    n_tests++;
    if (bus.STATE_OUT !== 2'd3 || bus.FAULT !== 1'b1) begin
      n_fail++; $display("FAIL conflict_over_stop state=%0d fault=%b exp 3 1", bus.STATE_OUT, bus.FAULT);
    end
    bus.CLR_FAULT = 1; tick(); bus.CLR_FAULT = 0;
    bus.START = 1; tick(); bus.START = 0;
    bus.STOP = 1; tick(); bus.STOP = 0;
    n_tests++;
    if (bus.STATE_OUT !== 2'd0 || bus.SETCOUNTER_OUT !== {4{16'd120}}) begin
      n_fail++; $display("FAIL stop_load state=%0d lanes=%h exp 0 0078x4", bus.STATE_OUT, bus.SETCOUNTER_OUT);
    end
  endtask

  task automatic test_async_reset();
    bus.START = 1; tick(); bus.START = 0;
    tick(); tick(); tick();
    #2 RST_N = 0;
    #1;
    n_tests++;
    if (bus.EN_OUT !== 4'b0000 || bus.STATE_OUT !== 2'd0 || bus.CYCLE_POS !== 7'd0 ||
        bus.FAULT !== 1'b0 || bus.SETCOUNTER_OUT !== {4{16'd120}}) begin
      n_fail++;
      $display("FAIL async_reset en=%b state=%0d pos=%0d fault=%b lanes=%h exp reset values",
               bus.EN_OUT, bus.STATE_OUT, bus.CYCLE_POS, bus.FAULT, bus.SETCOUNTER_OUT);
    end
    @(negedge CLK);
    RST_N = 1;
    m_state = 0; m_first = 0; m_load_left = 0; m_pos = 0;
    bus.START = 1; tick(); bus.START = 0;
    n_tests++;
    if (bus.STATE_OUT !== 2'd1) begin
      n_fail++; $display("FAIL post_reset_start state=%0d exp 1", bus.STATE_OUT);
    end
  endtask

  task automatic test_random();
    int r;
    int errs;
    int runs;
    logic [3:0] exp_en;
    logic [63:0] exp_lanes;
    do_reset();
    errs = 0;
    runs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.START     = ($urandom % 8) == 0;
      bus.STOP      = ($urandom % 60) == 0;
      bus.CLR_FAULT = ($urandom % 6) == 0;
      bus.FIRST_SEL = 2'($urandom);
      r = int'($urandom % 40);
      if (r == 0) begin
        bus.GREEN_IN = 4'($urandom); bus.YELLOW_IN = 4'($urandom);
      end else begin
        bus.GREEN_IN = 0; bus.YELLOW_IN = 0;
        if (r % 3 == 1) bus.GREEN_IN[$urandom % 4] = 1'b1;
        else if (r % 3 == 2) bus.YELLOW_IN[$urandom % 4] = 1'b1;
      end
      tick();
      if (m_state == 2) runs++;
      exp_en = (m_state == 2) ? 4'b1111 : 4'b0000;
      for (int k = 0; k < 4; k++)
        exp_lanes[16*k +: 16] = (m_state == 1 || m_state == 2) ? 16'(exp_preload(k, m_first)) : 16'(RED);
      n_tests++;
      if (int'(bus.STATE_OUT) != m_state || bus.EN_OUT !== exp_en || bus.SETCOUNTER_OUT !== exp_lanes ||
          bus.FAULT !== (m_state == 3) || int'(bus.CYCLE_POS) != m_pos) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc=%0d state=%0d/%0d en=%b/%b lanes=%h/%h fault=%b pos=%0d/%0d (got/exp)",
                   cyc, bus.STATE_OUT, m_state, bus.EN_OUT, exp_en, bus.SETCOUNTER_OUT, exp_lanes,
                   bus.FAULT, bus.CYCLE_POS, m_pos);
      end
    end
    clear_inputs();
    n_tests++;
    if (runs < 100) begin
      n_fail++; $display("FAIL random_coverage run_cycles=%0d exp>=100", runs);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_start_default();
    test_rotated();
    test_conflict();
    test_wrap_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
